kdf_buf_upd: RTL and testbench
==============================

KDF_BUF_UPD -- requirements
Module: kdf_buf_upd

Interface
REQ-001 SHALL have parameter KDF_BUF_SIZE, default 256, meaning the KDF buffer length in bytes.
REQ-002 SHALL have parameter INPUT_SIZE, default 64, meaning the A window / tail length in bytes.
REQ-003 SHALL have parameter KEY_SIZE, default 32, meaning the B window / tail length in bytes.
REQ-004 SHALL have parameter HASH_SIZE, default 32, meaning the hash result length in bytes.
REQ-005 SHALL have parameter ROUNDS, default 32, meaning the number of hash/update rounds per job.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port in_vld, input, 1 bit: A/B load valid from the buffer copier.
REQ-009 SHALL have port in_rdy, output, 1 bit: load ready.
REQ-010 SHALL have port a_i, input, (KDF_BUF_SIZE+INPUT_SIZE)*8 bits: initial A buffer.
REQ-011 SHALL have port b_i, input, (KDF_BUF_SIZE+KEY_SIZE)*8 bits: initial B buffer.
REQ-012 SHALL have port win_vld, output, 1 bit: window valid to the BLAKE2S engine.
REQ-013 SHALL have port win_rdy, input, 1 bit: window ready.
REQ-014 SHALL have port win_a, output, INPUT_SIZE*8 bits: the message window A[ptr +: INPUT_SIZE].
REQ-015 SHALL have port win_b, output, KEY_SIZE*8 bits: the key window B[ptr +: KEY_SIZE].
REQ-016 SHALL have port hash_vld, input, 1 bit: hash result valid.
REQ-017 SHALL have port hash_rdy, output, 1 bit: hash result ready.
REQ-018 SHALL have port hash, input, HASH_SIZE*8 bits: the hash result.
REQ-019 SHALL have port out_vld, output, 1 bit: final result valid.
REQ-020 SHALL have port out_rdy, input, 1 bit: final result ready.
REQ-021 SHALL have port out_data, output, KEY_SIZE*8 bits: the final KDF result.

Function
REQ-022 SHALL map byte k of every bus to bits [8k +: 8].
REQ-023 SHALL implement the FSM IDLE -> WIN -> WAIT_HASH -> UPDATE -> (WIN | OUT) -> IDLE.
REQ-024 SHALL assert in_rdy only in IDLE; on in_vld&in_rdy it SHALL register A and B, clear ptr (8 bit) and round to 0, and enter WIN.
REQ-025 SHALL assert win_vld only in WIN, with win_a and win_b held stable; on win_vld&win_rdy it SHALL enter WAIT_HASH.
REQ-026 SHALL assert hash_rdy only in WAIT_HASH; on hash_vld&hash_rdy it SHALL register the hash and enter UPDATE.
REQ-027 UPDATE (one cycle) SHALL set ptr_new to the sum of all hash bytes modulo 256, using the wrap-around 8-bit result.
REQ-028 UPDATE SHALL apply B[ptr_new+j] ^= hash[j] for j<HASH_SIZE.
REQ-029 UPDATE SHALL, after the XOR, mirror the tail when ptr_new < KEY_SIZE: B[KDF_BUF_SIZE+j] = B[j] for j<KEY_SIZE.
REQ-030 UPDATE SHALL, after the XOR, mirror the head when ptr_new > KDF_BUF_SIZE-HASH_SIZE: B[j] = B[KDF_BUF_SIZE+j] for j<KEY_SIZE.
REQ-031 UPDATE SHALL NOT mirror when ptr_new equals KDF_BUF_SIZE-HASH_SIZE exactly, or in any other case outside REQ-029/REQ-030.
REQ-032 SHALL never modify A after load.
REQ-033 UPDATE SHALL increment round and go to OUT if round was ROUNDS-1, else to WIN.
REQ-034 Latency SHALL be one cycle from load accept to win_vld, and two cycles from hash accept to the next win_vld or out_vld.
REQ-035 OUT SHALL assert out_vld with out_data[j] = B[ptr+j] ^ A[ptr+j] for j<KEY_SIZE, held stable until out_vld&out_rdy, which SHALL return the FSM to IDLE.
REQ-036 SHALL ignore in_vld, hash_vld and win_rdy in every state in which they are not handshaked.

Reset
REQ-037 rst SHALL asynchronously force IDLE, with ptr, round, A and B all zero, at any point of operation.
REQ-038 During and after rst: in_rdy=1 (after release), win_vld=0, hash_rdy=0, out_vld=0, win_a=0, win_b=0, out_data=0.
REQ-039 The first load after a mid-job reset SHALL start a fresh job with round=0 and ptr=0.

Verification
REQ-040 Reset then idle -> in_rdy=1, all valids 0, all data outputs 0.
REQ-041 Load A=0, B[k]=k mod 256, then hash of 32 bytes 0x01 -> ptr=32, next win_b[j]=(32+j)^0x01, no mirror.
REQ-042 Hash byte0=0x05 and all other bytes 0 -> ptr=5, B[5]^=5, B[256..287] equals B[0..31].
REQ-043 Hash byte0=0xFA and all other bytes 0 -> ptr=250, B[250..281] XORed, B[0..31] equals B[256..287].
REQ-044 Hash of 32 bytes 0xFF -> sum 8160 wraps to ptr=224, no mirror.
REQ-045 Two tests:
- Hold win_rdy and out_rdy low for 10 cycles -> outputs stable, ROUNDS=32 job completes.
- Assert rst in WAIT_HASH -> all valids 0 immediately, the reload runs the full 32 rounds.

Source files
------------

// File: rtl/kdf_buf_upd.sv
// KDF buffer update engine: serves A/B windows to a BLAKE2S core, folds each hash
// back into B at a hash-derived pointer, and emits B^A at the final pointer.
module kdf_buf_upd #(
  parameter int KDF_BUF_SIZE = 256,
  parameter int INPUT_SIZE   = 64,
  parameter int KEY_SIZE     = 32,
  parameter int HASH_SIZE    = 32,
  parameter int ROUNDS       = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_vld,
  output logic                                 in_rdy,
  input  logic [(KDF_BUF_SIZE+INPUT_SIZE)*8-1:0] a_i,
  input  logic [(KDF_BUF_SIZE+KEY_SIZE)*8-1:0]   b_i,
  output logic                                 win_vld,
  input  logic                                 win_rdy,
  output logic [INPUT_SIZE*8-1:0]              win_a,
  output logic [KEY_SIZE*8-1:0]                win_b,
  input  logic                                 hash_vld,
  output logic                                 hash_rdy,
  input  logic [HASH_SIZE*8-1:0]               hash,
  output logic                                 out_vld,
  input  logic                                 out_rdy,
  output logic [KEY_SIZE*8-1:0]                out_data
);

  localparam int AW = (KDF_BUF_SIZE + INPUT_SIZE) * 8;
  localparam int BW = (KDF_BUF_SIZE + KEY_SIZE) * 8;
  localparam int RW = $clog2(ROUNDS) + 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [8:0]    TAIL_LIM   = 9'(KEY_SIZE);
  localparam logic [8:0]    HEAD_LIM   = 9'(KDF_BUF_SIZE - HASH_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIN,
    S_WAIT_HASH,
    S_UPDATE,
    S_OUT
  } state_t;

  state_t                 r_state;
  logic [AW-1:0]          r_a;
  logic [BW-1:0]          r_b;
  logic [HASH_SIZE*8-1:0] r_hash;
  logic [7:0]             r_ptr;
  logic [RW-1:0]          r_round;
  logic                   r_in_rdy;
  logic                   r_win_vld;
  logic                   r_hash_rdy;
  logic                   r_out_vld;

  logic [7:0]             w_ptr_new;
  logic [BW-1:0]          w_b_upd;
  logic [10:0]            w_bit_ptr;

  // Byte sum wraps naturally in the 8-bit accumulator.
  always_comb begin
    w_ptr_new = '0;
    for (int j = 0; j < HASH_SIZE; j++) begin
      w_ptr_new = w_ptr_new + r_hash[j*8 +: 8];
    end
  end

  // XOR the hash in first, then repair whichever end of the circular buffer it touched.
  always_comb begin
    w_b_upd = r_b;
    for (int j = 0; j < HASH_SIZE; j++) begin
      w_b_upd[(int'(w_ptr_new) + j)*8 +: 8] = w_b_upd[(int'(w_ptr_new) + j)*8 +: 8] ^ r_hash[j*8 +: 8];
    end
    if ({1'b0, w_ptr_new} < TAIL_LIM) begin
      w_b_upd[KDF_BUF_SIZE*8 +: KEY_SIZE*8] = w_b_upd[0 +: KEY_SIZE*8];
    end else if ({1'b0, w_ptr_new} > HEAD_LIM) begin
      w_b_upd[0 +: KEY_SIZE*8] = w_b_upd[KDF_BUF_SIZE*8 +: KEY_SIZE*8];
    end
  end

  assign w_bit_ptr = {r_ptr, 3'b000};
  assign win_a     = r_a[w_bit_ptr +: INPUT_SIZE*8];
  assign win_b     = r_b[w_bit_ptr +: KEY_SIZE*8];
  assign out_data  = r_a[w_bit_ptr +: KEY_SIZE*8] ^ r_b[w_bit_ptr +: KEY_SIZE*8];
  assign in_rdy    = r_in_rdy;
  assign win_vld   = r_win_vld;
  assign hash_rdy  = r_hash_rdy;
  assign out_vld   = r_out_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_hash     <= '0;
      r_ptr      <= '0;
      r_round    <= '0;
      r_in_rdy   <= 1'b1;
      r_win_vld  <= 1'b0;
      r_hash_rdy <= 1'b0;
      r_out_vld  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_vld) begin
            r_a       <= a_i;
            r_b       <= b_i;
            r_ptr     <= '0;
            r_round   <= '0;
            r_in_rdy  <= 1'b0;
            r_win_vld <= 1'b1;
            r_state   <= S_WIN;
          end
        end
        S_WIN: begin
          if (win_rdy) begin
            r_win_vld  <= 1'b0;
            r_hash_rdy <= 1'b1;
            r_state    <= S_WAIT_HASH;
          end
        end
        S_WAIT_HASH: begin
          if (hash_vld) begin
            r_hash     <= hash;
            r_hash_rdy <= 1'b0;
            r_state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_b     <= w_b_upd;
          r_ptr   <= w_ptr_new;
          r_round <= r_round + RW'(1);
          if (r_round == LAST_ROUND) begin
            r_out_vld <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_win_vld <= 1'b1;
            r_state   <= S_WIN;
          end
        end
        S_OUT: begin
          if (out_rdy) begin
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_in_rdy   <= 1'b1;
          r_win_vld  <= 1'b0;
          r_hash_rdy <= 1'b0;
          r_out_vld  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kdf_buf_upd.sv
// Self-checking bench for kdf_buf_upd: byte-array reference model of the A/B buffers,
// directed edge-pointer hashes plus randomized jobs, stalls and a mid-job reset.
module tb_kdf_buf_upd;

  localparam int KB = 256;
  localparam int IS = 64;
  localparam int KS = 32;
  localparam int HS = 32;
  localparam int RN = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_vld;
  logic                   in_rdy;
  logic [(KB+IS)*8-1:0]   a_i;
  logic [(KB+KS)*8-1:0]   b_i;
  logic                   win_vld;
  logic                   win_rdy;
  logic [IS*8-1:0]        win_a;
  logic [KS*8-1:0]        win_b;
  logic                   hash_vld;
  logic                   hash_rdy;
  logic [HS*8-1:0]        hash;
  logic                   out_vld;
  logic                   out_rdy;
  logic [KS*8-1:0]        out_data;

  kdf_buf_upd #(
    .KDF_BUF_SIZE(KB), .INPUT_SIZE(IS), .KEY_SIZE(KS), .HASH_SIZE(HS), .ROUNDS(RN)
  ) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .a_i(a_i), .b_i(b_i),
    .win_vld(win_vld), .win_rdy(win_rdy), .win_a(win_a), .win_b(win_b),
    .hash_vld(hash_vld), .hash_rdy(hash_rdy), .hash(hash),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: buffers as plain byte arrays, pointer as an integer.
  byte unsigned am [KB+IS];
  byte unsigned bm [KB+KS];
  int           ptr_m;
  logic [HS*8-1:0] hq [RN];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {win_vld, hash_rdy, out_vld, in_rdy};
  endfunction

  function automatic logic [511:0] exp_win_a();
    logic [511:0] v = '0;
    for (int j = 0; j < IS; j++) v[8*j +: 8] = am[ptr_m + j];
    return v;
  endfunction

  function automatic logic [511:0] exp_win_b();
    logic [511:0] v = '0;
    for (int j = 0; j < KS; j++) v[8*j +: 8] = bm[ptr_m + j];
    return v;
  endfunction

  function automatic logic [511:0] exp_out();
    logic [511:0] v = '0;
    for (int j = 0; j < KS; j++) v[8*j +: 8] = am[ptr_m + j] ^ bm[ptr_m + j];
    return v;
  endfunction

  task automatic model_update(input logic [HS*8-1:0] h);
    int s = 0;
    for (int j = 0; j < HS; j++) s += int'(h[8*j +: 8]);
    s = s % 256;
    for (int j = 0; j < HS; j++) bm[s + j] ^= h[8*j +: 8];
    if (s < KS) begin
      for (int j = 0; j < KS; j++) bm[KB + j] = bm[j];
    end else if (s > KB - HS) begin
      for (int j = 0; j < KS; j++) bm[j] = bm[KB + j];
    end
    ptr_m = s;
  endtask

  task automatic model_clear();
    foreach (am[k]) am[k] = 8'h00;
    foreach (bm[k]) bm[k] = 8'h00;
    ptr_m = 0;
  endtask

  task automatic rand_bufs();
    foreach (am[k]) am[k] = 8'($urandom);
    foreach (bm[k]) bm[k] = 8'($urandom);
  endtask

  function automatic logic [HS*8-1:0] h_const(input logic [7:0] v);
    logic [HS*8-1:0] h;
    for (int j = 0; j < HS; j++) h[8*j +: 8] = v;
    return h;
  endfunction

  function automatic logic [HS*8-1:0] h_byte0(input logic [7:0] v);
    logic [HS*8-1:0] h = '0;
    h[7:0] = v;
    return h;
  endfunction

  function automatic logic [HS*8-1:0] h_rand();
    logic [HS*8-1:0] h;
    case ($urandom_range(0, 3))
      0: for (int j = 0; j < HS; j++) h[8*j +: 8] = 8'($urandom);
      1: h = h_byte0(8'($urandom_range(0, 40)));
      2: h = h_byte0(8'($urandom_range(215, 255)));
      default: h = h_byte0(8'd224);
    endcase
    return h;
  endfunction

  task automatic rand_hashes(input int from);
    for (int r = from; r < RN; r++) hq[r] = h_rand();
  endtask

  // Runs one job starting at a negedge; abort_rnd >= 0 pulses rst while waiting for that hash.
  task automatic run_job(input string name, input bit stall, input int abort_rnd, input bit directed);
    logic [KS*8-1:0] d41;
    chk($sformatf("%s_idle_flags", name), 512'(flags()), 512'(4'b0001));
    for (int j = 0; j < KB + IS; j++) a_i[8*j +: 8] = am[j];
    for (int j = 0; j < KB + KS; j++) b_i[8*j +: 8] = bm[j];
    ptr_m  = 0;
    in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    a_i    = ~a_i;
    b_i    = ~b_i;
    for (int r = 0; r < RN; r++) begin
      chk($sformatf("%s_r%0d_win_flags", name, r), 512'(flags()), 512'(4'b1000));
      chk($sformatf("%s_r%0d_win_a", name, r), 512'(win_a), exp_win_a());
      chk($sformatf("%s_r%0d_win_b", name, r), 512'(win_b), exp_win_b());
      if (stall && r == 0) begin
        in_vld   = 1'b1;
        hash_vld = 1'b1;
        hash     = h_rand();
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk($sformatf("%s_stall%0d_win_vld", name, c), 512'(win_vld), 512'(1'b1));
          chk($sformatf("%s_stall%0d_win_a", name, c), 512'(win_a), exp_win_a());
          chk($sformatf("%s_stall%0d_win_b", name, c), 512'(win_b), exp_win_b());
        end
        in_vld   = 1'b0;
        hash_vld = 1'b0;
      end
      win_rdy = 1'b1;
      @(negedge clk);
      win_rdy = 1'b0;
      chk($sformatf("%s_r%0d_hash_flags", name, r), 512'(flags()), 512'(4'b0100));
      if (r == abort_rnd) begin
        #2 rst = 1'b1;
        #1;
        chk($sformatf("%s_abort_flags", name), 512'(flags() & 4'b1110), 512'(4'b0000));
        chk($sformatf("%s_abort_win_a", name), 512'(win_a), 512'(0));
        chk($sformatf("%s_abort_win_b", name), 512'(win_b), 512'(0));
        chk($sformatf("%s_abort_out", name), 512'(out_data), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        return;
      end
      hash_vld = 1'b1;
      hash     = hq[r];
      @(negedge clk);
      hash_vld = 1'b0;
      hash     = h_rand();
      chk($sformatf("%s_r%0d_upd_flags", name, r), 512'(flags()), 512'(4'b0000));
      model_update(hq[r]);
      @(negedge clk);
      if (directed && r == 0) begin
        for (int j = 0; j < KS; j++) d41[8*j +: 8] = 8'(32 + j) ^ 8'h01;
        chk($sformatf("%s_ptr32_win_b", name), 512'(win_b), 512'(d41));
      end
    end
    chk($sformatf("%s_out_flags", name), 512'(flags()), 512'(4'b0010));
    chk($sformatf("%s_out_data", name), 512'(out_data), exp_out());
    if (stall) begin
      in_vld = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk($sformatf("%s_ostall%0d_vld", name, c), 512'(out_vld), 512'(1'b1));
        chk($sformatf("%s_ostall%0d_data", name, c), 512'(out_data), exp_out());
      end
      in_vld = 1'b0;
    end
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    chk($sformatf("%s_done_flags", name), 512'(flags()), 512'(4'b0001));
    $display("job %s: checks=%0d errors=%0d", name, checks, errors);
  endtask

  initial begin
    rst      = 1'b1;
    in_vld   = 1'b0;
    win_rdy  = 1'b0;
    hash_vld = 1'b0;
    out_rdy  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    hash     = '0;
    model_clear();
    @(negedge clk);
    chk("reset_valids", 512'(flags() & 4'b1110), 512'(4'b0000));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_flags", 512'(flags()), 512'(4'b0001));
    chk("idle_win_a", 512'(win_a), 512'(0));
    chk("idle_win_b", 512'(win_b), 512'(0));
    chk("idle_out", 512'(out_data), 512'(0));

    // Directed: A=0, B[k]=k, pointers 32, 5, 250, 0, 224; stalls on window and output.
    foreach (am[k]) am[k] = 8'h00;
    foreach (bm[k]) bm[k] = 8'(k);
    hq[0] = h_const(8'h01);
    hq[1] = h_byte0(8'h05);
    hq[2] = h_byte0(8'hFA);
    hq[3] = '0;
    hq[4] = h_const(8'hFF);
    rand_hashes(5);
    run_job("dir", 1'b1, -1, 1'b1);

    // Random B with head != tail exposes any wrong mirror decision.
    rand_bufs();
    hq[0] = h_const(8'hFF);
    hq[1] = '0;
    hq[2] = h_byte0(8'h05);
    hq[3] = h_byte0(8'hFA);
    hq[4] = h_byte0(8'hF0);
    hq[5] = '0;
    rand_hashes(6);
    run_job("edge", 1'b0, -1, 1'b0);

    rand_bufs();
    rand_hashes(0);
    run_job("abort", 1'b0, 3, 1'b0);

    rand_bufs();
    rand_hashes(0);
    run_job("reload", 1'b0, -1, 1'b0);

    rand_bufs();
    rand_hashes(0);
    run_job("rnd", 1'b1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
